// File: rtl/prbs_pkg.sv
// Shared types, default polynomial constants and helpers for the PRBS checker/generator.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam int unsigned PRBS_LFSR_W = 15;
  localparam int unsigned PRBS_TAP    = 14;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs_next_byte.sv
// Combinational 8-step Fibonacci LFSR advance: predicted byte (MSB first) and next state.
module prbs_next_byte
  import prbs_pkg::*;
#(
  parameter int unsigned LFSR_W = PRBS_LFSR_W,
  parameter int unsigned TAP    = PRBS_TAP
) (
  input  logic [LFSR_W-1:0] i_state,
  output logic [7:0]        o_byte,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] w_s;
  logic              w_b;

  always_comb begin
    w_s    = i_state;
    w_b    = 1'b0;
    o_byte = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_b    = w_s[LFSR_W-1] ^ w_s[TAP-1];
      o_byte = {o_byte[6:0], w_b};
      w_s    = {w_s[LFSR_W-2:0], w_b};
    end
    o_state = w_s;
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS byte checker with lock FSM and saturating error count.
// Optional saturating byte counter enabled by PRBS_CHK_BYTE_CNT_EN.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LFSR_W     = PRBS_LFSR_W,
  parameter int unsigned TAP        = PRBS_TAP,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clr_cnt,
  output logic        locked,
  output logic [31:0] err_cnt,
  output logic        err_pulse
`ifdef PRBS_CHK_BYTE_CNT_EN
  ,
  output logic [31:0] byte_cnt
`endif
);

  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [31:0]       r_bits_loaded;
  logic [7:0]        r_good_cnt;
  logic [7:0]        r_bad_cnt;
  logic              r_locked;
  logic              r_err_pulse;
  logic [31:0]       r_err_cnt;
`ifdef PRBS_CHK_BYTE_CNT_EN
  logic [31:0]       r_byte_cnt;
`endif

  logic [7:0]        w_exp;
  logic [7:0]        w_diff;
  logic [LFSR_W-1:0] w_pred_state;
  logic [LFSR_W-1:0] w_rx_state;
  logic [31:0]       w_bits_next;
  logic [32:0]       w_err_sum;
  logic              w_match;

  prbs_next_byte #(
    .LFSR_W (LFSR_W),
    .TAP    (TAP)
  ) u_next (
    .i_state (r_lfsr),
    .o_byte  (w_exp),
    .o_state (w_pred_state)
  );

  always_comb begin
    w_rx_state = r_lfsr;
    for (int unsigned i = 0; i < 8; i++) begin
      w_rx_state = {w_rx_state[LFSR_W-2:0], in_data[3'(7 - i)]};
    end
    w_diff      = w_exp ^ in_data;
    w_match     = (w_diff == '0) && (r_lfsr != '0);
    w_bits_next = r_bits_loaded + 32'd8;
    w_err_sum   = {1'b0, r_err_cnt} + 33'(popcount8(w_diff));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state       <= SEARCH;
      r_lfsr        <= '0;
      r_bits_loaded <= '0;
      r_good_cnt    <= '0;
      r_bad_cnt     <= '0;
      r_locked      <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_cnt     <= '0;
`ifdef PRBS_CHK_BYTE_CNT_EN
      r_byte_cnt    <= '0;
`endif
    end else begin
      r_err_pulse <= 1'b0;
      if (in_valid) begin
        case (r_state)
          SEARCH: begin
            r_lfsr        <= w_rx_state;
            r_bits_loaded <= w_bits_next;
            if (w_bits_next >= LFSR_W) begin
              r_state    <= VERIFY;
              r_good_cnt <= '0;
            end
          end
          VERIFY: begin
            r_lfsr <= w_rx_state;
            if (w_match) begin
              r_good_cnt <= r_good_cnt + 8'd1;
              if (r_good_cnt + 8'd1 == 8'(LOCK_CNT)) begin
                r_state   <= LOCKED;
                r_locked  <= 1'b1;
                r_bad_cnt <= '0;
              end
            end else begin
              r_good_cnt <= '0;
            end
          end
          LOCKED: begin
            r_lfsr    <= w_pred_state;
            r_err_cnt <= w_err_sum[32] ? '1 : w_err_sum[31:0];
`ifdef PRBS_CHK_BYTE_CNT_EN
            if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 32'd1;
`endif
            if (w_diff != '0) begin
              r_err_pulse <= 1'b1;
              r_bad_cnt   <= r_bad_cnt + 8'd1;
              if (r_bad_cnt + 8'd1 == 8'(UNLOCK_CNT)) begin
                r_state       <= SEARCH;
                r_locked      <= 1'b0;
                r_bits_loaded <= '0;
              end
            end else begin
              r_bad_cnt <= '0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
      // Placed after the FSM so a clear overrides any same-cycle accumulation.
      if (clr_cnt) begin
        r_err_cnt  <= '0;
`ifdef PRBS_CHK_BYTE_CNT_EN
        r_byte_cnt <= '0;
`endif
      end
    end
  end

  assign locked    = r_locked;
  assign err_cnt   = r_err_cnt;
  assign err_pulse = r_err_pulse;
`ifdef PRBS_CHK_BYTE_CNT_EN
  assign byte_cnt  = r_byte_cnt;
`endif

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side counterpart of the PRBS byte generator. It takes the 8-bit PRBS byte stream, self-synchronises a local LFSR to it and reports lock status and a saturating bit-error count. It sits at the far end of a link or loopback and qualifies the generator's output without sharing a seed.

## Interface
Parameters:
- LFSR_W, 15: LFSR length (polynomial x^LFSR_W + x^TAP + 1).
- TAP, 14: second feedback tap.
- LOCK_CNT, 4: consecutive matching bytes required to declare lock (range 1–255).
- UNLOCK_CNT, 4: consecutive errored bytes that drop lock (range 1–255).

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is a PRBS byte this cycle.
- in_data  in  8  received byte; MSB is the earliest bit in time.
- clr_cnt  in  1  synchronous clear of the counters.
- locked  out  1  checker is synchronised.
- err_cnt  out  32  accumulated bit errors while locked; saturates at 0xFFFF_FFFF.
- err_pulse  out  1  one-cycle pulse for each errored byte while locked.
- byte_cnt  out  32  bytes checked while locked; saturates. Present only with PRBS_CHK_BYTE_CNT_EN.

## Operation
- **Bit order.** The LFSR is Fibonacci-type. Next bit = s[LFSR_W-1] ^ s[TAP-1]; it is shifted into s[0]. Eight steps per byte; the first generated bit maps to bit 7.
- **State machine** (advances only on in_valid):
  - **SEARCH**
    - On each byte, the 8 received bits are shifted into the LFSR and `bits_loaded` increments by 8.
    - When `bits_loaded` ≥ LFSR_W, go to VERIFY with `good_cnt` = 0.
  - **VERIFY**
    - Form `exp` = the next 8 predicted bits, then shift the received bits (not the predicted bits) into the state.
    - If `exp` == in_data and the pre-shift state ≠ 0, increment `good_cnt`; otherwise clear `good_cnt`.
    - When `good_cnt` reaches LOCK_CNT, go to LOCKED.
    - The all-zero state never counts as a match, so an idle all-zero line cannot lock.
  - **LOCKED**
    - The LFSR free-runs on predicted bits.
    - `err_cnt` += popcount(exp ^ in_data).
    - Any nonzero difference pulses err_pulse and increments `bad_cnt`; a clean byte clears `bad_cnt`.
    - When `bad_cnt` reaches UNLOCK_CNT, go to SEARCH with `bits_loaded` = 0. err_cnt and byte_cnt are retained.
- **in_valid low:** no state, LFSR or counter change; err_pulse is 0.
- **clr_cnt:** sets err_cnt and byte_cnt to 0. It has priority over a simultaneous valid byte, whose errors and count are discarded. It does not affect the lock FSM.
- **Saturation:** err_cnt saturates, never wraps; a byte whose addition would overflow leaves it at 0xFFFF_FFFF. byte_cnt saturates the same way.

## Timing
- **Reset values:** state SEARCH, LFSR 0, `bits_loaded`/`good_cnt`/`bad_cnt` 0, locked 0, err_cnt 0, err_pulse 0, byte_cnt 0.
- **Registered outputs:** all outputs update on the CLK edge that samples the byte.
- **Lock:** locked rises on the edge sampling the LOCK_CNT-th consecutive matching byte. For LFSR_W=15, LOCK_CNT=4, the earliest lock is at the 6th valid byte (2 load + 4 verify).
- **Unlock:** locked falls on the edge sampling the UNLOCK_CNT-th consecutive errored byte. That byte's errors are counted.
- **Reset mid-stream:** RSTn low forces reset values immediately. The FSM restarts in SEARCH.

## Configuration
- Macro `PRBS_CHK_BYTE_CNT_EN`.
- **Defined:** the byte_cnt port and its 32-bit saturating counter exist. It increments per valid byte in LOCKED and is cleared by clr_cnt.
- **Undefined:** the port and counter are absent. All other behaviour is unchanged.

## Structure
- **Package `prbs_pkg`:** state enum (SEARCH, VERIFY, LOCKED), default LFSR_W/TAP constants, and a popcount8 function.
- **Sub-module `prbs_next_byte`:** combinational. Takes state and returns the predicted byte plus the 8-step next state. It is instantiated once here and is reusable by the generator.

## Test plan
- **Clean lock:** reset, then a clean generator stream (seed 0x0001, same polynomial), one byte per cycle → locked = 1 after the 6th byte; err_cnt stays 0; byte_cnt = 10 after 16 bytes.
- **Single-bit error:** while locked, flip bit 0 of one byte → err_cnt = 1, one err_pulse, locked stays 1.
- **Unlock and relock:** while locked, send 4 consecutive bytes XORed with 0xFF → err_cnt += 32, locked falls on the 4th; clean stream resumes → relock 6 bytes later; err_cnt retained.
- **All-zero line:** reset, send 20 bytes of 0x00 → locked stays 0.
- **Clear priority and stalls:** clr_cnt together with an errored valid byte → err_cnt = 0. in_valid gaps of 3 cycles between bytes → lock timing counted in valid bytes only.
- **Saturation and reset:** force err_cnt near 0xFFFF_FFFF, inject an 8-bit error → saturates at 0xFFFF_FFFF. RSTn low mid-stream → all outputs return to reset values asynchronously.
